// File: rtl/hazard_ctrl_if.sv
// Pipeline-side bundle for hazard_ctrl: ID/EX/MEM register specifiers in,
// PC / IF/ID load enables, flush strobes and statistics out.
interface hazard_ctrl_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_uses_rt;
  logic [REG_W-1:0] ex_rd;
  logic             ex_reg_write;
  logic             ex_mem_read;
  logic [REG_W-1:0] mem_rd;
  logic             mem_reg_write;
  logic             ex_branch;
  logic             ex_branch_taken;
  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_flush;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  // Handshake: there is no valid/ready pair. The datapath loads PC and IF/ID
  // on every rising edge where pc_write/ifid_write are 1; ifid_flush and
  // idex_flush override the loaded value with zero on that same edge.
  modport master (
    output id_rs, id_rt, id_uses_rt, ex_rd, ex_reg_write, ex_mem_read,
           mem_rd, mem_reg_write, ex_branch, ex_branch_taken,
    input  pc_write, ifid_write, ifid_flush, idex_flush,
           stall_count, flush_count
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_rd, ex_reg_write, ex_mem_read,
           mem_rd, mem_reg_write, ex_branch, ex_branch_taken,
    output pc_write, ifid_write, ifid_flush, idex_flush,
           stall_count, flush_count
  );
endinterface

// File: rtl/hazard_ctrl.sv
// RAW-hazard stall and taken-branch flush controller for a 5-stage MIPS pipe.
// Define HAZARD_FORWARDING_EN when a forwarding unit exists (load-use stalls only).
module hazard_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic         clk,
  input  logic         reset,
  hazard_ctrl_if.slave hz,
  output logic         dbg_stall,
  output logic [1:0]   dbg_left
);

  typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [1:0]       left_q, left_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;

  logic       branch_taken;
  logic       ex_match;
  logic       mem_match;
  logic [1:0] stall_cycles;
  logic       stall_inc;
  logic       flush_inc;
  logic       pc_write;
  logic       ifid_write;
  logic       ifid_flush;
  logic       idex_flush;

  assign branch_taken = hz.ex_branch & hz.ex_branch_taken;

  // Register 0 is hardwired, so a write to it never creates a dependency.
  assign ex_match  = hz.ex_reg_write && (hz.ex_rd != '0) &&
                     ((hz.ex_rd == hz.id_rs) || (hz.id_uses_rt && (hz.ex_rd == hz.id_rt)));
  assign mem_match = hz.mem_reg_write && (hz.mem_rd != '0) &&
                     ((hz.mem_rd == hz.id_rs) || (hz.id_uses_rt && (hz.mem_rd == hz.id_rt)));

`ifdef HAZARD_FORWARDING_EN
  assign stall_cycles = (ex_match && hz.ex_mem_read) ? 2'd1 : 2'd0;
`else
  assign stall_cycles = ex_match ? 2'd2 : (mem_match ? 2'd1 : 2'd0);
`endif

  always_comb begin
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    state_d    = state_q;
    left_d     = left_q;
    stall_inc  = 1'b0;
    flush_inc  = 1'b0;

    if (reset) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      state_d    = RUN;
      left_d     = 2'd0;
      flush_inc  = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if (stall_cycles != 2'd0) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
            stall_inc  = 1'b1;
            if (stall_cycles > 2'd1) begin
              left_d  = stall_cycles - 2'd1;
              state_d = STALL;
            end
          end
        end
        STALL: begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_flush = 1'b1;
          stall_inc  = 1'b1;
          // Leaving when the countdown hits zero also covers a corrupt left_q of 0.
          if (left_q <= 2'd1) begin
            left_d  = 2'd0;
            state_d = RUN;
          end else begin
            left_d = left_q - 2'd1;
          end
        end
        default: begin
          state_d = RUN;
          left_d  = 2'd0;
        end
      endcase
    end

    stall_count_d = stall_count_q;
    if (stall_inc && (stall_count_q != '1)) stall_count_d = stall_count_q + 1'b1;
    flush_count_d = flush_count_q;
    if (flush_inc && (flush_count_q != '1)) flush_count_d = flush_count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RUN;
      left_q        <= 2'd0;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      state_q       <= state_d;
      left_q        <= left_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign hz.pc_write    = pc_write;
  assign hz.ifid_write  = ifid_write;
  assign hz.ifid_flush  = ifid_flush;
  assign hz.idex_flush  = idex_flush;
  assign hz.stall_count = stall_count_q;
  assign hz.flush_count = flush_count_q;
  assign dbg_stall      = (state_q == STALL);
  assign dbg_left       = left_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed test-plan sequences plus random traffic,
// checked against a cycle-count reference model through an expected queue.
module tb_hazard_ctrl;
  localparam int REG_W = 5;
  localparam int CNT_W = 4;
  localparam int W     = 5 + 2 * CNT_W;
  localparam int CMAX  = (1 << CNT_W) - 1;

  // clock / reset block
  logic clk;
  logic reset;
  logic dbg_stall;
  logic [1:0] dbg_left;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();

  hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .hz        (bus),
    .dbg_stall (dbg_stall),
    .dbg_left  (dbg_left)
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  int n_cmp;
  int n_bad;

  // reference model: remaining extra stall cycles and plain integer counters
  int  m_rem;
  int  m_stall;
  int  m_flush;
  bit  m_known;

  function automatic bit reads_reg(input logic [REG_W-1:0] rd, input logic wr);
    return wr && (rd != 0) &&
           (rd == bus.id_rs || (bus.id_uses_rt && rd == bus.id_rt));
  endfunction

  function automatic int stall_needed();
`ifdef HAZARD_FORWARDING_EN
    if (reads_reg(bus.ex_rd, bus.ex_reg_write) && bus.ex_mem_read) return 1;
    return 0;
`else
    if (reads_reg(bus.ex_rd, bus.ex_reg_write)) return 2;
    if (reads_reg(bus.mem_rd, bus.mem_reg_write)) return 1;
    return 0;
`endif
  endfunction

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  // driver: apply one cycle of inputs, predict that cycle, advance the model
  task automatic drive(input logic rst, input int rs, input int rt, input logic urt,
                       input int exrd, input logic exw, input logic exmr,
                       input int memrd, input logic memw, input logic br, input logic tk);
    logic [3:0] ctl;
    logic [W-1:0] rec;
    bit taken;
    int need;
    @(posedge clk);
    #1;
    reset               = rst;
    bus.id_rs           = REG_W'(rs);
    bus.id_rt           = REG_W'(rt);
    bus.id_uses_rt      = urt;
    bus.ex_rd           = REG_W'(exrd);
    bus.ex_reg_write    = exw;
    bus.ex_mem_read     = exmr;
    bus.mem_rd          = REG_W'(memrd);
    bus.mem_reg_write   = memw;
    bus.ex_branch       = br;
    bus.ex_branch_taken = tk;
    taken = br && tk;
    need  = stall_needed();
    // ctl = {pc_write, ifid_write, ifid_flush, idex_flush}
    if (rst)              ctl = 4'b0011;
    else if (taken)       ctl = 4'b1111;
    else if (m_rem > 0)   ctl = 4'b0001;
    else if (need > 0)    ctl = 4'b0001;
    else                  ctl = 4'b1100;
    rec = {m_known, ctl, CNT_W'(m_stall), CNT_W'(m_flush)};
    exp_q.push_back(rec);
    if (rst) begin
      m_rem = 0; m_stall = 0; m_flush = 0; m_known = 1'b1;
    end else if (taken) begin
      m_rem = 0; m_flush = sat(m_flush + 1);
    end else if (m_rem > 0) begin
      m_rem--; m_stall = sat(m_stall + 1);
    end else if (need > 0) begin
      m_rem = need - 1; m_stall = sat(m_stall + 1);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1, 2, 1'b1, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  // monitor: outputs are stable by the falling edge after each drive
  initial begin
    logic [W-1:0] e;
    logic [3:0] act;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        act = {bus.pc_write, bus.ifid_write, bus.ifid_flush, bus.idex_flush};
        n_cmp++;
        if (act !== e[W-2 -: 4]) begin
          n_bad++;
          $display("FAIL ctl t=%0t actual=%b required=%b", $time, act, e[W-2 -: 4]);
        end
        if (e[W-1]) begin
          n_cmp++;
          if (bus.stall_count !== e[2*CNT_W-1 -: CNT_W]) begin
            n_bad++;
            $display("FAIL stall_count t=%0t actual=%0d required=%0d", $time,
                     bus.stall_count, e[2*CNT_W-1 -: CNT_W]);
          end
          n_cmp++;
          if (bus.flush_count !== e[CNT_W-1:0]) begin
            n_bad++;
            $display("FAIL flush_count t=%0t actual=%0d required=%0d", $time,
                     bus.flush_count, e[CNT_W-1:0]);
          end
        end
      end
    end
  end

  initial begin
    n_cmp = 0; n_bad = 0;
    m_rem = 0; m_stall = 0; m_flush = 0; m_known = 1'b0;
    reset = 1'b1;
    bus.id_rs = '0; bus.id_rt = '0; bus.id_uses_rt = 1'b0;
    bus.ex_rd = '0; bus.ex_reg_write = 1'b0; bus.ex_mem_read = 1'b0;
    bus.mem_rd = '0; bus.mem_reg_write = 1'b0;
    bus.ex_branch = 1'b0; bus.ex_branch_taken = 1'b0;

    // reset held 3 cycles, then quiet pipe
    for (int i = 0; i < 3; i++) drive(1'b1, 0, 0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    idle(3);
    // load-use on rs=5, then the same with rd=0
    drive(1'b0, 5, 1, 1'b0, 5, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 5, 1, 1'b0, 5, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    idle(2);
    drive(1'b0, 0, 1, 1'b0, 0, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    idle(1);
    // ALU producer in EX on rt=8, held while the pipe is frozen
    for (int i = 0; i < 2; i++) drive(1'b0, 3, 8, 1'b1, 8, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 3, 8, 1'b1, 0, 1'b0, 1'b0, 8, 1'b1, 1'b0, 1'b0);
    idle(2);
    // MEM-only match on rd=8; rt ignored when not used
    drive(1'b0, 3, 8, 1'b1, 0, 1'b0, 1'b0, 8, 1'b1, 1'b0, 1'b0);
    idle(1);
    drive(1'b0, 3, 8, 1'b0, 0, 1'b0, 1'b0, 8, 1'b1, 1'b0, 1'b0);
    // EX hazard then taken branch during the following cycle
    drive(1'b0, 9, 2, 1'b0, 9, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 9, 2, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b1);
    idle(2);
    // same-cycle load-use and taken branch; not-taken branch
    drive(1'b0, 6, 2, 1'b0, 6, 1'b1, 1'b1, 0, 1'b0, 1'b1, 1'b1);
    idle(1);
    drive(1'b0, 1, 2, 1'b1, 4, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    idle(1);
    // reset in the middle of a stall
    drive(1'b0, 7, 2, 1'b0, 7, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 7, 2, 1'b0, 7, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    idle(2);
    // 20 consecutive taken branches saturate flush_count
    for (int i = 0; i < 20; i++) drive(1'b0, 1, 2, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b1);
    idle(2);
    // random traffic over a small register range so matches are frequent
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 59) == 0), $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1),
            $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1),
            ($urandom_range(0, 5) == 0), $urandom_range(0, 1));
    end
    idle(1);

    // final report
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain actual=%0d pending required=0 pending", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
